// File: rtl/jtcps1_prog_sdram_pkg.sv
// Shared definitions for the ROM-download SDRAM responder.
// Holds the SDRAM command encodings ({ncs,nras,ncas,nwe}), the
// mode-register word and the controller state enumeration.
package jtcps1_prog_sdram_pkg;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_LMR   = 4'b0000;
    localparam logic [3:0] CMD_DESEL = 4'b1111;

    // Burst length 1, sequential, CAS latency 2, burst write.
    localparam logic [12:0] MODE_WORD = 13'h020;

    // Width of the shared wait counter and the refresh counter.
    localparam int unsigned CNT_W = 16;

    typedef enum logic [3:0] {
        StInitWait,
        StInitPre,
        StInitRef1,
        StInitRef2,
        StInitLmr,
        StIdle,
        StAct,
        StWr,
        StPre,
        StRef,
        StWait
    } state_e;

endpackage

// File: rtl/jtcps1_prog_refcnt.sv
// Refresh interval timer for the download-time SDRAM responder.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   en            count enable (high once SDRAM init is complete)
//   ref_ack       a REF command is being issued this cycle
//   ref_req       a refresh is pending
// The counter is free-running while enabled and wraps at REF_PERIOD-1,
// which is also where a request is raised. Requests coalesce: a new one
// arriving while one is pending leaves a single pending request.
module jtcps1_prog_refcnt
    import jtcps1_prog_sdram_pkg::*;
#(
    parameter int unsigned REF_PERIOD = 370
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic ref_ack,
    output logic ref_req
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;

    always_comb begin
        cnt_d = cnt_q;
        req_d = req_q;
        if (ref_ack) req_d = 1'b0;
        // A fresh request takes precedence over a clear in the same cycle.
        if (en) begin
            if (cnt_q == CNT_W'(REF_PERIOD - 1)) begin
                cnt_d = '0;
                req_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            req_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            req_q <= req_d;
        end
    end

    assign ref_req = req_q;

endmodule

// File: rtl/jtcps1_prog_sdram.sv
// SDRAM-side responder for the ROM download programming port.
// Runs the SDRAM power-up init, then turns each held prog_we request into
// one ACT / WRITE / PRE sequence, pulsing sdram_ack on the WRITE cycle.
// Auto-refresh is issued from IDLE whenever the refresh timer requests it.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   prog_addr[21:0]                word address, row [21:9], column [8:0]
//   prog_data[7:0], prog_mask[1:0] byte to write, active-low byte enables
//   prog_we                        request, held until sdram_ack
//   sdram_ack                      one-cycle pulse with the WRITE command
//   init_done                      high once the init sequence completes
//   sdram_*                        registered SDRAM pins
module jtcps1_prog_sdram
    import jtcps1_prog_sdram_pkg::*;
#(
    parameter int unsigned INIT_WAIT  = 4800,
    parameter int unsigned TRCD       = 2,
    parameter int unsigned TWR        = 2,
    parameter int unsigned TRP        = 2,
    parameter int unsigned TRFC       = 7,
    parameter int unsigned TMRD       = 2,
    parameter int unsigned REF_PERIOD = 370,
    parameter logic [1:0]  BANK       = 2'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] prog_addr,
    input  logic [7:0]  prog_data,
    input  logic [1:0]  prog_mask,
    input  logic        prog_we,
    output logic        sdram_ack,
    output logic        init_done,
    output logic [12:0] sdram_a,
    output logic [1:0]  sdram_ba,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe,
    output logic        sdram_dqml,
    output logic        sdram_dqmh,
    output logic        sdram_ncs,
    output logic        sdram_nras,
    output logic        sdram_ncas,
    output logic        sdram_nwe,
    output logic        sdram_cke
);

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [12:0]      a_q, a_d;
    logic [1:0]       ba_q, ba_d;
    logic [15:0]      dq_q, dq_d;
    logic             oe_q, oe_d;
    logic [1:0]       dqm_q, dqm_d;      // [1] = high byte, [0] = low byte
    logic             ack_q, ack_d;
    logic             done_q, done_d;
    logic             cke_q;
    logic [8:0]       col_q, col_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       mask_q, mask_d;
    logic             ref_req, ref_ack;

    jtcps1_prog_refcnt #(
        .REF_PERIOD (REF_PERIOD)
    ) u_refcnt (
        .clk     (clk),
        .rst     (rst),
        .en      (done_q),
        .ref_ack (ref_ack),
        .ref_req (ref_req)
    );

    // Every command state issues its command on the pins for one cycle and
    // hands over to StWait, which burns N cycles (loaded with N-1) before
    // returning to ret_q.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        wait_d  = wait_q;
        cmd_d   = CMD_NOP;
        a_d     = a_q;
        ba_d    = ba_q;
        dq_d    = dq_q;
        oe_d    = 1'b0;
        dqm_d   = 2'b11;
        ack_d   = 1'b0;
        col_d   = col_q;
        data_d  = data_q;
        mask_d  = mask_q;
        ref_ack = 1'b0;

        case (state_q)
            StInitWait: begin
                // This cycle plus INIT_WAIT-1 wait cycles of NOP.
                wait_d  = CNT_W'(INIT_WAIT - 2);
                ret_d   = StInitPre;
                state_d = StWait;
            end
            StInitPre: begin
                cmd_d   = CMD_PRE;
                a_d     = 13'h0400;     // a[10]: precharge all banks
                ba_d    = 2'd0;
                wait_d  = CNT_W'(TRP - 1);
                ret_d   = StInitRef1;
                state_d = StWait;
            end
            StInitRef1: begin
                cmd_d   = CMD_REF;
                wait_d  = CNT_W'(TRFC - 1);
                ret_d   = StInitRef2;
                state_d = StWait;
            end
            StInitRef2: begin
                cmd_d   = CMD_REF;
                wait_d  = CNT_W'(TRFC - 1);
                ret_d   = StInitLmr;
                state_d = StWait;
            end
            StInitLmr: begin
                cmd_d   = CMD_LMR;
                a_d     = MODE_WORD;
                ba_d    = 2'd0;
                wait_d  = CNT_W'(TMRD - 1);
                ret_d   = StIdle;
                state_d = StWait;
            end
            StIdle: begin
                if (ref_req) begin
                    // Refresh first; a pending prog_we stays held.
                    cmd_d   = CMD_REF;
                    ref_ack = 1'b1;
                    wait_d  = CNT_W'(TRFC - 1);
                    ret_d   = StIdle;
                    state_d = StWait;
                end else if (prog_we) begin
                    cmd_d   = CMD_ACT;
                    ba_d    = BANK;
                    a_d     = prog_addr[21:9];
                    col_d   = prog_addr[8:0];
                    data_d  = prog_data;
                    mask_d  = prog_mask;
                    wait_d  = CNT_W'(TRCD - 1);
                    ret_d   = StWr;
                    state_d = StWait;
                end
            end
            StWr: begin
                cmd_d   = CMD_WRITE;
                ba_d    = BANK;
                a_d     = {4'b0000, col_q};   // a[10] = 0: no auto-precharge
                dq_d    = {data_q, data_q};
                oe_d    = 1'b1;
                dqm_d   = mask_q;
                ack_d   = 1'b1;
                wait_d  = CNT_W'(TWR - 1);
                ret_d   = StPre;
                state_d = StWait;
            end
            StPre: begin
                cmd_d   = CMD_PRE;
                ba_d    = BANK;
                a_d     = 13'h0000;     // single-bank precharge
                wait_d  = CNT_W'(TRP - 1);
                ret_d   = StIdle;
                state_d = StWait;
            end
            StWait: begin
                if (wait_q == '0) begin
                    state_d = ret_q;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            // StAct and StRef are never entered: IDLE issues both commands
            // directly to keep the request-to-ack latency at 1+TRCD.
            default: state_d = StIdle;
        endcase

        done_d = done_q | (state_d == StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StInitWait;
            ret_q   <= StInitWait;
            wait_q  <= '0;
            cmd_q   <= CMD_DESEL;
            a_q     <= '0;
            ba_q    <= '0;
            dq_q    <= '0;
            oe_q    <= 1'b0;
            dqm_q   <= 2'b11;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            cke_q   <= 1'b0;
            col_q   <= '0;
            data_q  <= '0;
            mask_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            wait_q  <= wait_d;
            cmd_q   <= cmd_d;
            a_q     <= a_d;
            ba_q    <= ba_d;
            dq_q    <= dq_d;
            oe_q    <= oe_d;
            dqm_q   <= dqm_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            cke_q   <= 1'b1;
            col_q   <= col_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

    assign {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe} = cmd_q;
    assign sdram_a      = a_q;
    assign sdram_ba     = ba_q;
    assign sdram_dq_out = dq_q;
    assign sdram_dq_oe  = oe_q;
    assign sdram_dqml   = dqm_q[0];
    assign sdram_dqmh   = dqm_q[1];
    assign sdram_ack    = ack_q;
    assign init_done    = done_q;
    assign sdram_cke    = cke_q;

endmodule

// File: tb/tb_jtcps1_prog_sdram.sv
// Directed self-checking bench for jtcps1_prog_sdram.
// Pin cycle numbering: cyc counts rising edges; values sampled just after
// the falling edge belong to the cycle started by the latest rising edge.
module tb_jtcps1_prog_sdram;

    localparam logic [3:0] NOP   = 4'b0111;
    localparam logic [3:0] ACT   = 4'b0011;
    localparam logic [3:0] WRITE = 4'b0100;
    localparam logic [3:0] PRE   = 4'b0010;
    localparam logic [3:0] REF   = 4'b0001;
    localparam logic [3:0] LMR   = 4'b0000;
    localparam logic [3:0] DESEL = 4'b1111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [21:0] prog_addr = '0;
    logic [7:0]  prog_data = '0;
    logic [1:0]  prog_mask = 2'b11;
    logic        prog_we = 1'b0;
    logic        sdram_ack, init_done;
    logic [12:0] sdram_a;
    logic [1:0]  sdram_ba;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe, sdram_dqml, sdram_dqmh;
    logic        sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe, sdram_cke;

    jtcps1_prog_sdram dut (
        .clk          (clk),
        .rst          (rst),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .prog_mask    (prog_mask),
        .prog_we      (prog_we),
        .sdram_ack    (sdram_ack),
        .init_done    (init_done),
        .sdram_a      (sdram_a),
        .sdram_ba     (sdram_ba),
        .sdram_dq_out (sdram_dq_out),
        .sdram_dq_oe  (sdram_dq_oe),
        .sdram_dqml   (sdram_dqml),
        .sdram_dqmh   (sdram_dqmh),
        .sdram_ncs    (sdram_ncs),
        .sdram_nras   (sdram_nras),
        .sdram_ncas   (sdram_ncas),
        .sdram_nwe    (sdram_nwe),
        .sdram_cke    (sdram_cke)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pin monitor: records the latest occurrence of each command.
    logic [3:0]  cmd;
    int          ack_cnt = 0, wr_cnt = 0, ref_cnt = 0;
    int          last_ack = -1, last_act = -1, last_pre = -1, last_ref = -1;
    logic [12:0] act_row, pre_a;
    logic [1:0]  act_ba;
    logic [8:0]  wr_col;
    logic        wr_a10, wr_oe, wr_dqml, wr_dqmh;
    logic [15:0] wr_dq;

    always @(negedge clk) begin
        cmd = {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe};
        if (sdram_ack === 1'b1) begin
            ack_cnt++;
            last_ack = cyc;
        end
        if (cmd == ACT) begin
            last_act = cyc;
            act_row  = sdram_a;
            act_ba   = sdram_ba;
        end
        if (cmd == WRITE) begin
            wr_cnt++;
            wr_col  = sdram_a[8:0];
            wr_a10  = sdram_a[10];
            wr_dq   = sdram_dq_out;
            wr_oe   = sdram_dq_oe;
            wr_dqml = sdram_dqml;
            wr_dqmh = sdram_dqmh;
        end
        if (cmd == PRE) begin
            last_pre = cyc;
            pre_a    = sdram_a;
        end
        if (cmd == REF) begin
            ref_cnt++;
            last_ref = cyc;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Advance to the next non-NOP, non-deselect command.
    task automatic next_cmd(input int max, output logic [3:0] c, output int t,
                            output logic [12:0] a, output logic [1:0] ba);
        logic found = 1'b0;
        int   n = 0;
        c = NOP; t = -1; a = '0; ba = '0;
        while (!found && n < max) begin
            tick();
            n++;
            if (cmd != NOP && cmd != DESEL) begin
                found = 1'b1;
                c = cmd; t = cyc; a = sdram_a; ba = sdram_ba;
            end
        end
    endtask

    task automatic wait_ack(input int max);
        int n = 0;
        tick();
        while (sdram_ack !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        check_val("ack_seen", sdram_ack, 1'b1);
    endtask

    task automatic check_init(input int t0);
        logic [3:0]  c;
        int          t;
        logic [12:0] a;
        logic [1:0]  ba;
        tick();
        check_val("cke_first", sdram_cke, 1'b1);
        check_val("nop_first", cmd, NOP);
        next_cmd(6000, c, t, a, ba);
        check_val("init_pre_cmd", c, PRE);
        check_val("init_pre_t", t - t0, 4801);
        check_val("init_pre_a10", a[10], 1'b1);
        next_cmd(20, c, t, a, ba);
        check_val("init_ref1_cmd", c, REF);
        check_val("init_ref1_t", t - t0, 4804);
        next_cmd(20, c, t, a, ba);
        check_val("init_ref2_cmd", c, REF);
        check_val("init_ref2_t", t - t0, 4812);
        next_cmd(20, c, t, a, ba);
        check_val("init_lmr_cmd", c, LMR);
        check_val("init_lmr_t", t - t0, 4820);
        check_val("init_lmr_a", a, 13'h020);
        check_val("init_lmr_ba", ba, 2'd0);
        tick();
        check_val("init_done_lmr1", init_done, 1'b0);
        tick();
        check_val("init_done_lmr2", init_done, 1'b1);
    endtask

    // One isolated write from IDLE with no refresh pending.
    task automatic do_write(input logic [21:0] addr, input logic [7:0] data,
                            input logic [1:0] mask, input logic [12:0] e_row,
                            input logic [8:0] e_col, input logic [15:0] e_dq,
                            input logic e_l, input logic e_h);
        int c0, ca, acks0;
        c0 = cyc;
        acks0 = ack_cnt;
        prog_addr = addr; prog_data = data; prog_mask = mask; prog_we = 1'b1;
        wait_ack(20);
        ca = cyc;
        check_val("act_t", last_act - c0, 1);
        check_val("act_row", act_row, e_row);
        check_val("act_ba", act_ba, 2'd0);
        check_val("ack_t", ca - c0, 4);
        check_val("wr_cmd", cmd, WRITE);
        check_val("wr_col", wr_col, e_col);
        check_val("wr_a10", wr_a10, 1'b0);
        check_val("wr_dq", wr_dq, e_dq);
        check_val("wr_oe", wr_oe, 1'b1);
        check_val("wr_dqml", wr_dqml, e_l);
        check_val("wr_dqmh", wr_dqmh, e_h);
        tick();
        prog_we = 1'b0;
        check_val("post_wr_oe", sdram_dq_oe, 1'b0);
        check_val("post_wr_dqm", {sdram_dqmh, sdram_dqml}, 2'b11);
        check_val("post_wr_ack", sdram_ack, 1'b0);
        tick();
        tick();
        check_val("pre_t", last_pre - ca, 3);
        check_val("pre_a10", pre_a[10], 1'b0);
        check_val("ack_once", ack_cnt - acks0, 1);
        tick(); tick(); tick();
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int t0, t_ref, acks0, wrs0, prev_ack, prev_refs;

        // Reset state
        tick(); tick(); tick();
        check_val("rst_cmd", cmd, DESEL);
        check_val("rst_cke", sdram_cke, 1'b0);
        check_val("rst_a", sdram_a, 13'h0);
        check_val("rst_ba", sdram_ba, 2'd0);
        check_val("rst_oe", sdram_dq_oe, 1'b0);
        check_val("rst_dqm", {sdram_dqmh, sdram_dqml}, 2'b11);
        check_val("rst_ack", sdram_ack, 1'b0);
        check_val("rst_done", init_done, 1'b0);
        rst = 1'b0;
        t0 = cyc;
        check_init(t0);

        // Isolated writes: even byte, odd byte, both masked at top address
        do_write(22'h12345, 8'hA5, 2'b10, 13'h091, 9'h145, 16'hA5A5, 1'b0, 1'b1);
        do_write(22'h00000, 8'h3C, 2'b01, 13'h000, 9'h000, 16'h3C3C, 1'b1, 1'b0);
        do_write(22'h3FFFFF, 8'h5A, 2'b11, 13'h1FFF, 9'h1FF, 16'h5A5A, 1'b1, 1'b1);
        check_val("no_early_ref", ref_cnt, 2);

        // prog_we raised in the cycle the first refresh request sets
        t_ref = t0 + 4822 + 371;
        while (cyc < t_ref - 1) tick();
        acks0 = ack_cnt;
        prog_addr = 22'h0ABCD; prog_data = 8'h77; prog_mask = 2'b00; prog_we = 1'b1;
        wait_ack(40);
        check_val("coll_ref_t", last_ref, t_ref);
        check_val("coll_act_t", last_act - t_ref, 8);
        check_val("coll_ack_t", last_ack - t_ref, 11);
        check_val("coll_col", wr_col, 9'h1CD);
        tick();
        prog_we = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        check_val("coll_one_ack", ack_cnt - acks0, 1);

        // 64 back-to-back requests; prog_we dropped one cycle after each ack
        acks0 = ack_cnt;
        wrs0 = wr_cnt;
        prev_ack = 0;
        prev_refs = ref_cnt;
        for (int i = 0; i < 64; i++) begin
            logic [8:0]  ecol;
            logic [7:0]  edat;
            ecol = 9'(i * 7);
            edat = 8'(i + 8'h40);
            prog_addr = {13'(i + 1), ecol};
            prog_data = edat;
            prog_mask = 2'(i);
            prog_we = 1'b1;
            wait_ack(40);
            check_val("b2b_row", act_row, 13'(i + 1));
            check_val("b2b_col", wr_col, ecol);
            check_val("b2b_dq", wr_dq, {edat, edat});
            if (i > 0)
                check_val("b2b_period", last_ack - prev_ack,
                          (ref_cnt != prev_refs) ? 17 : 9);
            prev_ack = last_ack;
            prev_refs = ref_cnt;
            tick();
            prog_we = 1'b0;
            tick();
        end
        tick(); tick(); tick(); tick(); tick();
        check_val("b2b_acks", ack_cnt - acks0, 64);
        check_val("b2b_writes", wr_cnt - wrs0, 64);

        // Reset between ACT and WRITE
        acks0 = ack_cnt;
        wrs0 = wr_cnt;
        prev_ack = last_act;
        prog_addr = 22'h01234; prog_data = 8'h11; prog_mask = 2'b00; prog_we = 1'b1;
        for (int n = 0; n < 40 && last_act == prev_ack; n++) tick();
        check_val("rst_mid_act", cmd, ACT);
        tick();
        rst = 1'b1;
        #1;
        check_val("rst_mid_cmd", {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe}, DESEL);
        check_val("rst_mid_cke", sdram_cke, 1'b0);
        check_val("rst_mid_done", init_done, 1'b0);
        check_val("rst_mid_oe", sdram_dq_oe, 1'b0);
        tick(); tick(); tick();
        prog_we = 1'b0;
        rst = 1'b0;
        t0 = cyc;
        check_init(t0);
        check_val("rst_mid_no_ack", ack_cnt - acks0, 0);
        check_val("rst_mid_no_wr", wr_cnt - wrs0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
